mm_c_drain: RTL and testbench

Result-drain stage directly downstream of the 8x8 matrix-multiply engine. On the engine's `done`, it sweeps the engine's C result RAM through its read port and absorbs the fixed RAM read latency. It then presents the 64 signed 19-bit elements as a valid/ready stream with a last marker, in row-major or column-major order. Credit-based issue into a small FIFO guarantees no element is lost or duplicated under arbitrary downstream back-pressure.

---
 rtl/mm.sv | 8 +
 rtl/mm_drain_fifo.sv | 41 ++++
 rtl/mm_c_drain.sv | 108 ++++++++++
 tb/tb_mm_c_drain.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mm.sv
// mm: shared constants, element type and drain-state encoding for the matrix-multiply block
package mm;
  localparam int MM_N  = 8;
  localparam int MM_CW = 19;
  localparam int MM_AW = 6;
  typedef logic signed [18:0] mm_c_t;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} mm_drain_state_e;
endpackage

// File: rtl/mm_drain_fifo.sv
// mm_drain_fifo: small synchronous FIFO holding {index, element} beats for the drain stream
module mm_drain_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 25
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  // storage and circular pointers; a same-cycle push and pop leaves the count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q == PW'(DEPTH-1) ? '0 : wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q == PW'(DEPTH-1) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/mm_c_drain.sv
// mm_c_drain: sweeps the C result RAM after done and streams 64 elements with credit-based issue
module mm_c_drain import mm::*; #(
  parameter int N          = MM_N,
  parameter int DW         = MM_CW,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 done,
  input  logic                 col_major,
  output logic                 load_mem,
  output logic [MM_AW-1:0]     addrC,
  input  logic signed [DW-1:0] rdC,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic [MM_AW-1:0]     m_idx,
  output logic                 m_last,
  output logic                 busy,
  output logic                 drain_done
);
  localparam int AW = MM_AW;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int IW = $clog2(RD_LAT+1);
  localparam logic [AW-1:0] LAST = AW'(N*N-1);
  mm_drain_state_e state_q, state_d;
  logic            done_q, col_q, col_d;
  logic [AW-1:0]   k_q, k_d, beat_q, beat_d, addr_q, addr_n;
  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]   tag_q [RD_LAT];
  logic [IW-1:0]   inflight;
  logic [CW-1:0]   cnt;
  logic            issue, push, pop, full, empty;
  logic [DW+AW-1:0] head;
  assign inflight   = IW'($countones(vld_q));
  assign m_valid    = !empty;
  assign pop        = m_valid && m_ready;
  assign push       = vld_q[RD_LAT-1];
  assign addr_n     = col_q ? AW'((int'(k_q) % N) * N + int'(k_q) / N) : k_q;
  assign issue      = state_q == ISSUE && !(full && !pop) &&
                      int'(inflight) + int'(cnt) - int'(pop) < FIFO_DEPTH;
  assign addrC      = issue ? addr_n : addr_q;
  assign load_mem   = state_q == ISSUE || state_q == FLUSH;
  assign busy       = load_mem;
  assign drain_done = state_q == DONE;
  assign m_data     = head[DW-1:0];
  assign m_idx      = head[DW+AW-1:DW];
  assign m_last     = m_valid && beat_q == LAST;
  mm_drain_fifo #(.DEPTH(FIFO_DEPTH), .W(DW+AW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .din_i   ({tag_q[RD_LAT-1], rdC}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );
  // drain sequencing: start on a done rising edge in IDLE only, finish once nothing is left in flight or buffered
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    col_d   = col_q;
    beat_d  = pop ? beat_q + AW'(1) : beat_q;
    case (state_q)
      IDLE: if (done && !done_q) begin
        state_d = ISSUE;
        col_d   = col_major;
        k_d     = '0;
        beat_d  = '0;
      end
      ISSUE: if (issue) begin
        k_d     = k_q + AW'(1);
        state_d = k_q == LAST ? FLUSH : ISSUE;
      end
      FLUSH: state_d = inflight == '0 && (empty || (cnt == CW'(1) && pop)) ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  // state, counters, held address and the read-latency tag pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      col_q   <= 1'b0;
      k_q     <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done;
      col_q    <= col_d;
      k_q      <= k_d;
      beat_q   <= beat_d;
      addr_q   <= addrC;
      vld_q[0] <= issue;
      tag_q[0] <= addr_n;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mm_c_drain.sv
// tb_mm_c_drain: randomized self-checking bench for mm_c_drain against an order/latency reference model
module tb_mm_c_drain;
  logic clk = 1'b0, reset_n = 1'b0, done = 1'b0, col_major = 1'b0, m_ready = 1'b0;
  logic load_mem, m_valid, m_last, busy, drain_done;
  logic [5:0] addrC, m_idx;
  logic signed [18:0] m_data;
  logic signed [18:0] rdC = '0, p1 = '0;
  logic signed [18:0] mem [64];
  int n_vec = 0, n_err = 0;

  mm_c_drain dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .col_major  (col_major),
    .load_mem   (load_mem),
    .addrC      (addrC),
    .rdC        (rdC),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_idx      (m_idx),
    .m_last     (m_last),
    .busy       (busy),
    .drain_done (drain_done)
  );

  always #5 clk = ~clk;

  // C RAM model with a two-cycle read latency
  always @(posedge clk) begin
    p1  <= mem[addrC];
    rdC <= p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int addr_of(input int k, input bit col);
    return col ? (k % 8) * 8 + k / 8 : k;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_load_mem"}, load_mem, 0);
    check({tag, "_addrC"}, addrC, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_idx"}, m_idx, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drain_done"}, drain_done, 0);
  endtask

  // one drain: cycle 0 is the cycle done rises; pct is m_ready duty, stall forces m_ready low for cycles 1..stall
  task automatic drain(input bit col, input int pct, input int stall, input int retrig,
                       input int rst_at, input bit full_speed);
    int c, b, first, idx;
    bit pv;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    col_major = col;
    done      = 1'b1;
    m_ready   = 1'b0;
    c = 0; b = 0; first = -1; pv = 0;
    check("start_busy", busy, 0);
    forever begin
      @(negedge clk);
      c++;
      if (c == 2) done = 1'b0;
      if (c > 3000) begin
        check("timeout", c, 0);
        break;
      end
      if (pv) check("valid_held", m_valid, 1);
      if (drain_done) begin
        check("beats", b, 64);
        check("done_busy", busy, 0);
        if (full_speed) check("done_cycle", c, 68);
        break;
      end
      check("busy", busy, 1);
      check("load_mem", load_mem, 1);
      if (c >= 5 && c <= stall) check("addr_frozen", addrC, addr_of(3, col));
      m_ready = (c <= stall) ? 1'b0 : ($urandom_range(99) < pct);
      if (m_valid) begin
        if (first < 0) begin
          first = c;
          if (full_speed) check("first_valid", c, 4);
        end
        if (b < 64) begin
          idx = addr_of(b, col);
          check("idx", m_idx, idx);
          check("data", m_data, mem[idx]);
          check("last", m_last, b == 63);
        end else check("extra_beat", m_valid, 0);
      end
      pv = m_valid && !m_ready;
      if (m_valid && m_ready) b++;
      if (retrig >= 0 && b >= retrig) done = 1'b1;
      if (rst_at >= 0 && b == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        check_reset("midrst_hold");
        reset_n = 1'b1;
        break;
      end
    end
    m_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 19'(i - 32);
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    drain(0, 100, 0, -1, -1, 1);
    drain(1, 100, 0, -1, -1, 1);
    for (int i = 0; i < 64; i++) mem[i] = 19'($urandom);
    drain(0, 30, 0, -1, -1, 0);
    drain(1, 30, 0, -1, -1, 0);
    mem[0]  = -19'sd262144;
    mem[63] = 19'sd262143;
    drain(0, 100, 20, -1, -1, 0);
    drain(1, 60, 0, 10, -1, 0);
    repeat (10) begin
      @(negedge clk);
      check("no_retrig_busy", busy, 0);
      check("no_retrig_valid", m_valid, 0);
    end
    drain(0, 50, 0, -1, 30, 0);
    drain(0, 100, 0, -1, -1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
